hazard_stall_controller: RTL

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_stall_controller.sv | 94 +++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard detection: load-use, branch-operand and mult/div structural stalls,
// redirect flush control, mult/div occupancy tracking and a saturating stall counter.
module hazard_stall_controller #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_EX_mem_read,
  input  logic              ID_EX_reg_write,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              EX_MEM_mem_read,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic              IF_ID_uses_rs,
  input  logic              IF_ID_uses_rt,
  input  logic              IF_ID_is_branch,
  input  logic              IF_ID_is_md,
  input  logic              IF_ID_reads_hilo,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              stat_clear,
  output logic              pc_stall,
  output logic              IF_ID_stall,
  output logic              mux_control_hazard,
  output logic              IF_ID_flush,
  output logic              md_start,
  output logic              md_busy,
  output logic [7:0]        md_count,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY);

  // Register 0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic src_match(input logic              uses,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dest);
    return uses && (src != '0) && (src == dest);
  endfunction

  logic match_ex;
  logic match_mem;
  logic load_use;
  logic branch_alu;
  logic branch_load;
  logic md_struct;
  logic stall;

  assign match_ex  = src_match(IF_ID_uses_rs, IF_ID_rs, ID_EX_rd) ||
                     src_match(IF_ID_uses_rt, IF_ID_rt, ID_EX_rd);
  assign match_mem = src_match(IF_ID_uses_rs, IF_ID_rs, EX_MEM_rd) ||
                     src_match(IF_ID_uses_rt, IF_ID_rt, EX_MEM_rd);

  assign load_use    = ID_EX_mem_read && match_ex;
  assign branch_alu  = IF_ID_is_branch && ID_EX_reg_write && !ID_EX_mem_read && match_ex;
  assign branch_load = IF_ID_is_branch && EX_MEM_mem_read && match_mem;
  assign md_struct   = md_busy && (IF_ID_is_md || IF_ID_reads_hilo);
  assign stall       = load_use || branch_alu || branch_load || md_struct;

  assign pc_stall           = stall;
  assign IF_ID_stall        = stall;
  assign mux_control_hazard = stall;

  // A redirect seen during a stall is dropped; the branch re-resolves once released.
  assign IF_ID_flush = (branch_taken || jump) && !stall;
  assign md_start    = IF_ID_is_md && !stall;
  assign md_busy     = (md_count != 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the asynchronous reset clears occupancy without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_count <= 8'd0;
    end else if (md_start) begin
      md_count <= MD_LOAD;
    end else if (md_busy) begin
      md_count <= md_count - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stat_clear) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
